// File: rtl/inst_fetch_if.sv
// Byte-wide read channel between the instruction-fetch stage and the memory controller.
interface inst_fetch_if;
  logic        memReq_out;
  logic [31:0] memAddr_out;
  logic [7:0]  memData_in;
  logic        memDone_in;

  modport master (
    output memReq_out,
    output memAddr_out,
    input  memData_in,
    input  memDone_in
  );

  modport slave (
    input  memReq_out,
    input  memAddr_out,
    output memData_in,
    output memDone_in
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: direct-mapped one-word-per-line cache with byte-serial refill
// from the memory controller, stall request to PC and squash on jump/branch redirect.
module inst_fetch #(
  parameter int INDEX_BITS = 6,
  parameter int STALL_W    = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [STALL_W-1:0] stall_in,
  input  logic [31:0]        pc_in,
  input  logic               pcJump_in,
  inst_fetch_if.master       mem,
  output logic               stallReq_out,
  output logic [31:0]        pc_out,
  output logic [31:0]        inst_out,
  output logic               instValid_out
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t            state_q;
  logic [1:0]        idx_q;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       fetch_pc_q;
  logic [23:0]       byte_buf_q;
  logic [31:0]       pc_q;
  logic [31:0]       inst_q;
  logic              inst_valid_q;
  logic [LINES-1:0]  line_valid_q;

  logic [31:0]       data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];

  logic [INDEX_BITS-1:0] lk_index;
  logic [TAG_W-1:0]      lk_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic [31:0]           fill_word;
  logic [1:0]            idx_d;
  logic [31:0]           mem_addr_d;
  logic                  hit;
  logic                  last_byte;
  logic                  cache_we;
  logic                  stall_hold;
  logic                  ready;
  logic                  unused_stall_bits;

  assign stall_hold        = stall_in[1];
  assign unused_stall_bits = ^{stall_in[STALL_W-1:2], stall_in[0]};

  assign lk_index   = pc_in[INDEX_BITS+1:2];
  assign lk_tag     = pc_in[31:INDEX_BITS+2];
  assign fill_index = fetch_pc_q[INDEX_BITS+1:2];
  assign fill_tag   = fetch_pc_q[31:INDEX_BITS+2];
  assign hit        = line_valid_q[lk_index] && (tag_mem[lk_index] == lk_tag);

  assign idx_d      = idx_q + 2'd1;
  assign mem_addr_d = mem_addr_q + 32'd1;
  assign last_byte  = (state_q == S_FETCH) && (idx_q == 2'd3) && mem.memDone_in;
  assign fill_word  = {mem.memData_in, byte_buf_q};
  // A redirect in the final-byte cycle wins: the refilled word is dropped, not cached.
  assign cache_we   = rdy_in && !rst_in && !pcJump_in && last_byte;

  // Low stall request lets PC advance on the same edge the word is registered.
  assign ready        = ((state_q == S_IDLE) && hit) || last_byte || pcJump_in;
  assign stallReq_out = !(rdy_in && ready);

  assign mem.memReq_out  = mem_req_q && rdy_in;
  assign mem.memAddr_out = mem_addr_q;
  assign pc_out          = pc_q;
  assign inst_out        = inst_q;
  assign instValid_out   = inst_valid_q;

  always_ff @(posedge clk_in) begin
    if (cache_we) begin
      data_mem[fill_index] <= fill_word;
      tag_mem[fill_index]  <= fill_tag;
    end
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_line_valid
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        line_valid_q[gi] <= 1'b0;
      end else if (cache_we && (fill_index == INDEX_BITS'(gi))) begin
        line_valid_q[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      fetch_pc_q   <= 32'd0;
      byte_buf_q   <= 24'd0;
      pc_q         <= 32'd0;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
    end else if (rdy_in) begin
      if (pcJump_in) begin
        state_q      <= S_IDLE;
        idx_q        <= 2'd0;
        mem_req_q    <= 1'b0;
        inst_q       <= 32'd0;
        inst_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!stall_hold) begin
              if (hit) begin
                pc_q         <= pc_in;
                inst_q       <= data_mem[lk_index];
                inst_valid_q <= 1'b1;
              end else begin
                state_q      <= S_FETCH;
                idx_q        <= 2'd0;
                mem_req_q    <= 1'b1;
                mem_addr_q   <= pc_in;
                fetch_pc_q   <= pc_in;
                inst_q       <= 32'd0;
                inst_valid_q <= 1'b0;
              end
            end
          end
          S_FETCH: begin
            if (mem.memDone_in) begin
              idx_q      <= idx_d;
              mem_addr_q <= mem_addr_d;
              case (idx_q)
                2'd0:    byte_buf_q[7:0]   <= mem.memData_in;
                2'd1:    byte_buf_q[15:8]  <= mem.memData_in;
                2'd2:    byte_buf_q[23:16] <= mem.memData_in;
                default: begin
                  state_q   <= S_IDLE;
                  mem_req_q <= 1'b0;
                  if (!stall_hold) begin
                    pc_q         <= fetch_pc_q;
                    inst_q       <= fill_word;
                    inst_valid_q <= 1'b1;
                  end
                end
              endcase
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: scoreboard of expected {pc, inst} deliveries checked by a monitor,
// plus a byte-serial memory responder with selectable wait-state pattern.
module tb_inst_fetch;
  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall_in;
  logic [31:0] pc_in;
  logic        pcJump_in;
  logic        stallReq_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        instValid_out;

  inst_fetch_if mem_bus ();

  inst_fetch #(.INDEX_BITS(6), .STALL_W(6)) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .stall_in     (stall_in),
    .pc_in        (pc_in),
    .pcJump_in    (pcJump_in),
    .mem          (mem_bus),
    .stallReq_out (stallReq_out),
    .pc_out       (pc_out),
    .inst_out     (inst_out),
    .instValid_out(instValid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [63:0] exp_q[$];
  logic [31:0] addr_log[$];
  logic [7:0]  mem [0:1023];
  int          done_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory controller model: answers memReq_out every cycle (mode 0) or every other cycle (mode 1).
  initial begin
    logic        phase;
    logic        prev_req;
    logic        prev_done;
    logic [31:0] prev_addr;
    logic        done;
    phase = 1'b1; prev_req = 1'b0; prev_done = 1'b0; prev_addr = 32'd0;
    mem_bus.memDone_in = 1'b0;
    mem_bus.memData_in = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (prev_req && mem_bus.memReq_out)
        check("addr_step", mem_bus.memAddr_out, prev_done ? prev_addr + 32'd1 : prev_addr);
      done = 1'b0;
      if (mem_bus.memReq_out) begin
        done  = (done_mode == 0) || phase;
        phase = ~phase;
      end else begin
        phase = 1'b1;
      end
      mem_bus.memDone_in = done;
      mem_bus.memData_in = done ? mem[mem_bus.memAddr_out[9:0]] : 8'h00;
      if (done) addr_log.push_back(mem_bus.memAddr_out);
      prev_req  = mem_bus.memReq_out;
      prev_done = done;
      prev_addr = mem_bus.memAddr_out;
    end
  end

  // Monitor: a cycle with stallReq low, rdy high, IF not held and no redirect is a delivery,
  // visible on the outputs one edge later.
  initial begin
    logic        del_prev;
    logic [63:0] e;
    del_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (del_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL spurious_delivery: got pc %h inst %h expected none", pc_out, inst_out);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", pc_out, e[63:32]);
          check("deliver_inst", inst_out, e[31:0]);
          check("deliver_valid", 32'(instValid_out), 32'd1);
        end
      end
      del_prev = !rst_in && !stallReq_out && rdy_in && !stall_in[1] && !pcJump_in;
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] word);
    @(posedge clk); #1;
    pc_in    = pc;
    stall_in = 6'b000000;
    exp_q.push_back({pc, word});
  endtask

  task automatic wait_deliver(output int n, output bit saw_req);
    bit ok;
    n = 0; saw_req = 0; ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_bus.memReq_out) saw_req = 1;
      if (!stallReq_out) begin ok = 1; break; end
      n++;
      @(posedge clk); #1;
    end
    check("deliver_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    stall_in = 6'b000010;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] word, output int n, output bit saw_req);
    issue(pc, word);
    wait_deliver(n, saw_req);
  endtask

  initial begin
    int n;
    bit saw;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    {mem[3], mem[2], mem[1], mem[0]}                 = 32'h0000_0013;
    {mem[259], mem[258], mem[257], mem[256]}         = 32'h00A0_0093;
    {mem[263], mem[262], mem[261], mem[260]}         = 32'h1234_5678;
    {mem[515], mem[514], mem[513], mem[512]}         = 32'hDEAD_BEEF;
    {mem[771], mem[770], mem[769], mem[768]}         = 32'hCAFE_F00D;
    {mem[1027-4], mem[1026-4], mem[1025-4], mem[1024-4]} = 32'h0000_0000;

    rst_in = 1'b1; rdy_in = 1'b1; stall_in = 6'b000010; pc_in = 32'd0; pcJump_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc_out, 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_valid", 32'(instValid_out), 32'd0);
    check("rst_req", 32'(mem_bus.memReq_out), 32'd0);
    check("rst_addr", mem_bus.memAddr_out, 32'd0);
    @(posedge clk); #1;
    rst_in = 1'b0;

    // Cold miss at 0x0, memory answers every cycle.
    addr_log.delete();
    fetch(32'h0, 32'h0000_0013, n, saw);
    check("miss0_stall_cycles", 32'(n), 32'd4);
    check("miss0_nbytes", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("miss0_addr", addr_log[i], 32'(i));

    // Same address now hits with no memory traffic.
    fetch(32'h0, 32'h0000_0013, n, saw);
    check("hit0_stall_cycles", 32'(n), 32'd0);
    check("hit0_no_req", 32'(saw), 32'd0);

    // Miss at 0x104 with a wait state between every byte.
    done_mode = 1;
    fetch(32'h104, 32'h1234_5678, n, saw);
    check("miss104_stall_cycles", 32'(n), 32'd7);
    done_mode = 0;

    // Redirect after two bytes of a miss at 0x200.
    addr_log.delete();
    @(posedge clk); #1; pc_in = 32'h200; stall_in = 6'b000000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; pcJump_in = 1'b1;
    @(negedge clk);
    check("jump_stallreq", 32'(stallReq_out), 32'd0);
    @(posedge clk); #1; pcJump_in = 1'b0; stall_in = 6'b000010;
    @(negedge clk);
    check("jump_req_drop", 32'(mem_bus.memReq_out), 32'd0);
    check("jump_bubble_valid", 32'(instValid_out), 32'd0);
    check("jump_bubble_inst", inst_out, 32'd0);
    check("jump_pc_held", pc_out, 32'h104);
    check("jump_nbytes", 32'(addr_log.size()), 32'd3);
    fetch(32'h200, 32'hDEAD_BEEF, n, saw);
    check("refetch200_misses", 32'(n), 32'd4);

    // 0x100 shares an index with 0x0 and evicts it.
    fetch(32'h100, 32'h00A0_0093, n, saw);
    check("miss100_stall_cycles", 32'(n), 32'd4);
    fetch(32'h0, 32'h0000_0013, n, saw);
    check("alias0_misses", 32'(n), 32'd4);

    // IF held while the miss at 0x300 completes; afterwards it hits.
    addr_log.delete();
    @(posedge clk); #1; pc_in = 32'h300; stall_in = 6'b000000;
    @(posedge clk); #1; stall_in = 6'b000010;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stallReq_out) break;
      n++;
      @(posedge clk); #1;
    end
    check("stallfill_cycles", 32'(n), 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    check("stallfill_valid_held", 32'(instValid_out), 32'd0);
    check("stallfill_pc_held", pc_out, 32'h0);
    check("stallfill_req_drop", 32'(mem_bus.memReq_out), 32'd0);
    check("stallfill_nbytes", 32'(addr_log.size()), 32'd4);
    fetch(32'h300, 32'hCAFE_F00D, n, saw);
    check("stallfill_hit", 32'(n), 32'd0);
    check("stallfill_no_req", 32'(saw), 32'd0);

    // rdy_in low in the middle of a miss at 0x104 (evicted? no: index 1, still cached) -> use 0x3C0.
    addr_log.delete();
    {mem[963], mem[962], mem[961], mem[960]} = 32'h0BAD_C0DE;
    issue(32'h3C0, 32'h0BAD_C0DE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; rdy_in = 1'b0;
    @(negedge clk);
    check("rdy0_req", 32'(mem_bus.memReq_out), 32'd0);
    check("rdy0_stallreq", 32'(stallReq_out), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rdy0_addr_frozen", mem_bus.memAddr_out, 32'h3C2);
    @(posedge clk); #1; rdy_in = 1'b1;
    @(negedge clk);
    check("rdy1_req", 32'(mem_bus.memReq_out), 32'd1);
    check("rdy1_addr", mem_bus.memAddr_out, 32'h3C2);
    @(posedge clk); #1;
    wait_deliver(n, saw);
    check("rdy_nbytes", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("rdy_addr", addr_log[i], 32'h3C0 + 32'(i));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
